// File: rtl/logic_unit_pipe_if.sv
// Request/result bus for logic_unit_pipe.
// The master side offers requests and accepts results; the slave side is the
// pipeline itself.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             acc_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             parity;

  modport master (
    output in_valid, op, acc_mode, a, b, out_ready,
    input  in_ready, out_valid, y, zero, parity
  );

  modport slave (
    input  in_valid, op, acc_mode, a, b, out_ready,
    output in_ready, out_valid, y, zero, parity
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit with a valid/ready handshake on both sides.
// Stage 1 holds the captured request; stage 2 holds the registered result
// with its zero/parity flags. An optional accumulator can stand in for
// operand b and is reloaded with the result of every accumulate request.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_clr,
  logic_unit_pipe_if.slave  bus,
  output logic [WIDTH-1:0]  acc,
  output logic [CNT_W-1:0]  done_cnt
);

  typedef logic [WIDTH-1:0] word_t;

  // Bitwise operation table; every result is exactly WIDTH bits, no carries.
  function automatic word_t logic_op(input logic [2:0] sel,
                                     input word_t      opa,
                                     input word_t      opb);
    word_t r;
    case (sel)
      3'b000:  r = ~opa;
      3'b001:  r = opa & opb;
      3'b010:  r = opa | opb;
      3'b011:  r = ~(opa & opb);
      3'b100:  r = ~(opa | opb);
      3'b101:  r = opa ^ opb;
      3'b110:  r = ~(opa ^ opb);
      default: r = opa;
    endcase
    return r;
  endfunction

  logic       vld_p1;
  logic       vld_p2;
  logic [2:0] op_p1;
  logic       mode_p1;
  word_t      a_p1;
  word_t      b_p1;
  word_t      opb_p1;
  word_t      res_p1;
  word_t      y_p2;
  logic       zero_p2;
  logic       parity_p2;
  logic       accept;
  logic       advance;
  logic       out_fire;

  // ---- stage 0 -> 1: request acceptance ----
  assign advance      = vld_p1 && (!vld_p2 || bus.out_ready);
  assign bus.in_ready = !vld_p1 || !vld_p2 || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_fire     = vld_p2 && bus.out_ready;

  // Stage-1 occupancy: set on accept, cleared when the request moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
    end else if (advance) begin
      vld_p1 <= 1'b0;
    end
  end

  // Stage-1 payload capture; contents only matter while vld_p1 is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p1   <= bus.op;
      mode_p1 <= bus.acc_mode;
      a_p1    <= bus.a;
      b_p1    <= bus.b;
    end
  end

  // ---- stage 1 -> 2: compute and register the result ----
  // The accumulator value seen here is the one present at the advance edge,
  // so a clear on the same edge does not affect the in-flight result.
  assign opb_p1 = mode_p1 ? acc : b_p1;
  assign res_p1 = logic_op(op_p1, a_p1, opb_p1);

  // Result register: loads on advance, holds under backpressure, drains on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2    <= 1'b0;
      y_p2      <= '0;
      zero_p2   <= 1'b1;
      parity_p2 <= 1'b0;
    end else if (advance) begin
      vld_p2    <= 1'b1;
      y_p2      <= res_p1;
      zero_p2   <= (res_p1 == '0);
      parity_p2 <= ^res_p1;
    end else if (out_fire) begin
      vld_p2    <= 1'b0;
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.y         = y_p2;
  assign bus.zero      = zero_p2;
  assign bus.parity    = parity_p2;

  // Accumulator: clear wins over an accumulate load on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (advance && mode_p1) begin
      acc <= res_p1;
    end
  end

  // Completed output handshakes, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else if (out_fire) begin
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (>=1).
REQ-002 Parameter CNT_W, default 16, width of the completed-transaction counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream request valid.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 op  input  3  operation select, sampled at accept.
REQ-008 acc_mode  input  1  when 1, operand b is replaced by the accumulator; sampled at accept.
REQ-009 acc_clr  input  1  synchronous accumulator clear, not gated by the handshake.
REQ-010 a  input  WIDTH  operand A.
REQ-011 b  input  WIDTH  operand B.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 y  output  WIDTH  registered result.
REQ-015 zero  output  1  registered flag, y == 0.
REQ-016 parity  output  1  registered flag, XOR-reduction of y.
REQ-017 acc  output  WIDTH  current accumulator value.
REQ-018 done_cnt  output  CNT_W  count of completed output handshakes.

Function
REQ-019 op encoding SHALL be bitwise:
- 000 ~a
- 001 a&b
- 010 a|b
- 011 ~(a&b)
- 100 ~(a|b)
- 101 a^b
- 110 ~(a^b)
- 111 a (pass)
REQ-020 Accept: a request SHALL be accepted on a rising edge where in_valid && in_ready; a, b, op and acc_mode are captured into stage 1 (s1_valid set).
REQ-021 Stage 1 SHALL advance to stage 2 when s1_valid && (!out_valid || out_ready); on this edge the result is computed and y, zero, parity are loaded and out_valid is set.
REQ-022 in_ready SHALL equal !s1_valid || (!out_valid || out_ready), combinationally.
REQ-023 Latency SHALL be 2 cycles from accept edge to out_valid, with no backpressure; throughput is 1 request per cycle.
REQ-024 With out_valid high and out_ready low, y, zero, parity and out_valid SHALL hold stable.
REQ-025 out_valid SHALL clear after an output handshake unless stage 1 advances on the same edge.
REQ-026 Results SHALL emerge in accept order, with no loss or duplication; at most 2 requests are in flight.
REQ-027 acc_mode=1: the stage-2 computation SHALL use the acc value present at the advance edge as operand b.
REQ-028 acc_mode=1: acc SHALL load the result on the advance edge, so back-to-back accumulate ops chain correctly.
REQ-029 acc_mode=0 requests SHALL NOT modify acc.
REQ-030 acc_clr=1 SHALL set acc to 0 on that edge.
- Clear has priority over an accumulate load on the same edge.
- The in-flight result on that edge uses the pre-clear acc.
REQ-031 done_cnt SHALL increment by 1 on each out_valid && out_ready edge and wrap from 2^CNT_W-1 to 0.
REQ-032 Arithmetic SHALL be bitwise only; no carries, and every result is exactly WIDTH bits.

Reset
REQ-033 rst_n low SHALL immediately, independent of clk, set:
- s1_valid=0, out_valid=0
- y=0, zero=1, parity=0
- acc=0, done_cnt=0
REQ-034 While rst_n is low, in_ready SHALL be 1 and no request is accepted.
REQ-035 Reset asserted mid-operation SHALL discard in-flight requests without emitting them.
REQ-036 The first accept SHALL occur on the first rising edge with rst_n high.

Verification (WIDTH=8 unless noted)
REQ-037 The bench SHALL cover scenario 1, reset: pulse rst_n low between edges -> out_valid=0, y=0x00, zero=1, acc=0x00, done_cnt=0 without a clock edge.
REQ-038 The bench SHALL cover scenario 2, basic op: a=0xA5, b=0x0F, op=101, out_ready=1 -> 2 cycles later y=0xAA, zero=0, parity=0, done_cnt=1.
REQ-039 The bench SHALL cover scenario 3, backpressure: out_ready=0, offer 3 requests (op=001, a=0xFF, b=0x01/0x02/0x04).
- Expected: 2 accepted, in_ready=0 on the third.
- Then raise out_ready: outputs 0x01, 0x02, 0x04 in order, third accepted as space frees.
REQ-040 The bench SHALL cover scenario 4, accumulate: acc_clr, then back-to-back acc_mode=1 op=010 with a=0x01 then a=0x80 -> y=0x01 then 0x81, acc=0x81.
- Follow-up: acc_clr on the same edge as an accumulate load -> acc=0x00.
REQ-041 The bench SHALL cover scenario 5, mid-flight reset: two requests in flight, out_valid=1, rst_n low -> out_valid=0 at once, no result emitted after release.
REQ-042 The bench SHALL cover scenario 6, counter wrap, with CNT_W=4: 16 output handshakes -> done_cnt returns to 0; also sweep all 8 op codes with a=0x3C, b=0x5A against REQ-019.
